aes_result_serializer: RTL and testbench
========================================

// Module: aes_result_serializer
// PURPOSE
//  Consumes the 128-bit Result/Ry pair from the AES output-select stage.
//  Captures each new result and streams it out as OUT_W-bit words, MSB first, over a valid/ready handshake.
//  Sits between the output selector and the byte-wide host/UART transmit path.
// PARAMETERS
//  WIDTH  128  captured result width; must be an integer multiple of OUT_W
//  OUT_W  8    output word width; NWORDS = WIDTH/OUT_W (16 at defaults)
// PORTS
//  Clk     in   1      system clock, rising edge
//  Rst     in   1      asynchronous reset, active-high
//  Result  in   WIDTH  selected PT/CT block from output selector
//  Ry      in   1      result-ready level from output selector
//  DReady  in   1      downstream sink accepts Dout this cycle
//  ClrOvf  in   1      synchronous clear of Ovf
//  Dout    out  OUT_W  current output word
//  DValid  out  1      Dout valid
//  Busy    out  1      1 while a block is held (SEND or DONE)
//  Done    out  1      one-cycle pulse after the last word is accepted
//  Ovf     out  1      sticky: a new result arrived while Busy and was dropped
// BEHAVIOUR
//  Reset (any time, incl. mid-block): state=IDLE; Dout=0, DValid=0, Busy=0, Done=0, Ovf=0; Ry_q=0; count=0; shift reg=0.
//  Trigger: start = Ry & ~Ry_q (rising edge, Ry_q registered). A held-high Ry gives exactly one capture.
//  IDLE: on start, load shift reg <= Result, count <= 0, go SEND. DValid rises the next cycle (1-cycle latency).
//  SEND: DValid=1, Dout = shift[WIDTH-1 -: OUT_W].
//   - DValid & DReady: shift left by OUT_W, count++. On the beat with count==NWORDS-1, go DONE.
//   - DReady=0: hold Dout, DValid and count unchanged (no data change while stalled).
//  DONE: DValid=0, Done=1 for exactly one cycle, Busy=1, then IDLE.
//  Overrun: start in SEND or DONE sets Ovf=1; the new Result is ignored and the current block is unaffected.
//  Ovf: cleared only by Rst or ClrOvf=1. If ClrOvf and an overrun occur in the same cycle, set wins (Ovf=1).
//  Busy=1 in SEND and DONE, otherwise 0. Minimum start-to-start spacing without overrun: NWORDS+2 cycles.
//  count width = clog2(NWORDS+1). The top word of Result is always sent first; no wrap or repeat of words.
//  Result changes while in SEND/DONE have no effect (value captured at start only).
// CONFIGURATION
//  SERIALIZER_CHKSUM_EN defined: after the last data word, SEND emits one extra word = XOR of all NWORDS
//   data words (same handshake). DONE follows acceptance of this checksum word (NWORDS+1 beats total).
//  Not defined: exactly NWORDS beats per block; no checksum logic is synthesised.
// TESTING
//  T1 reset: assert Rst mid-cycle async -> all outputs 0 immediately, without waiting for a Clk edge.
//  T2 basic: Result=128'h03c18e199ba5296289328eca914a59aa, Ry 0->1, DReady=1 -> DValid next cycle;
//     Dout sequence 03,c1,8e,19,...,59,aa over 16 consecutive cycles; Done pulses 1 cycle; Busy=0 after.
//  T3 backpressure: Result=128'h5b448dd8c1beb2c7653f07f878c2c8e0, DReady toggling 1,0,0,1,... ->
//     Dout holds during stalls; the same 16 bytes 5b,44,...,c8,e0 arrive in order; Done after the byte e0.
//  T4 level Ry: hold Ry=1 for 40 cycles -> exactly one block sent, Ovf stays 0.
//  T5 overrun: Ry edge at byte 5 of a block -> Ovf=1, current block completes unchanged, no second block;
//     ClrOvf=1 -> Ovf=0 the next cycle.
//  T6 reset mid-op: Rst at byte 8 -> IDLE, DValid=0; a fresh Ry edge restarts from byte 0.
//     Checksum build: T2 emits a 17th byte = XOR of the 16 data bytes before Done.

Source files
------------

// File: rtl/aes_result_serializer.sv
// Captures a WIDTH-bit AES result on the rising edge of Ry and streams it out MSB-first
// as OUT_W-bit words over a valid/ready handshake. Optional macro SERIALIZER_CHKSUM_EN appends an XOR checksum word.
module aes_result_serializer #(
   parameter int WIDTH = 128,
   parameter int OUT_W = 8
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic [WIDTH-1:0] Result,
   input  logic             Ry,
   input  logic             DReady,
   input  logic             ClrOvf,
   output logic [OUT_W-1:0] Dout,
   output logic             DValid,
   output logic             Busy,
   output logic             Done,
   output logic             Ovf
);

   localparam int NWORDS = WIDTH / OUT_W;
   localparam int CW     = $clog2(NWORDS + 1);

`ifdef SERIALIZER_CHKSUM_EN
   localparam logic [CW-1:0] LAST_BEAT = CW'(NWORDS);
`else
   localparam logic [CW-1:0] LAST_BEAT = CW'(NWORDS - 1);
`endif

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_SEND = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state_q, state_d;
   logic             ry_q;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic             start;
   logic [OUT_W-1:0] top_word;

`ifdef SERIALIZER_CHKSUM_EN
   logic [OUT_W-1:0] chk_q, chk_d;
`endif

   assign start    = Ry & ~ry_q;
   assign top_word = shift_q[WIDTH-1 -: OUT_W];

   always_comb begin
      // NOTE: every variable gets a default here so no path can infer a latch.
      state_d = state_q;
      shift_d = shift_q;
      cnt_d   = cnt_q;
`ifdef SERIALIZER_CHKSUM_EN
      chk_d   = chk_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               shift_d = Result;
               cnt_d   = '0;
`ifdef SERIALIZER_CHKSUM_EN
               chk_d   = '0;
`endif
               state_d = S_SEND;
            end
         end
         S_SEND: begin
            if (DReady) begin
               shift_d = shift_q << OUT_W;
               cnt_d   = cnt_q + 1'b1;
`ifdef SERIALIZER_CHKSUM_EN
               // Once the data is shifted out top_word is zero, so the checksum beat leaves chk unchanged.
               chk_d   = chk_q ^ top_word;
`endif
               if (cnt_q == LAST_BEAT) state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // A trigger while a block is held is dropped and flagged; flagging beats clearing.
   always_comb begin
      ovf_d = ovf_q;
      if (start && (state_q != S_IDLE)) ovf_d = 1'b1;
      else if (ClrOvf)                  ovf_d = 1'b0;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_q <= S_IDLE;
         ry_q    <= 1'b0;
         shift_q <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ry_q    <= Ry;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
      end
   end

`ifdef SERIALIZER_CHKSUM_EN
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) chk_q <= '0;
      else     chk_q <= chk_d;
   end
`endif

   assign DValid = (state_q == S_SEND);
   assign Busy   = (state_q != S_IDLE);
   assign Done   = (state_q == S_DONE);
   assign Ovf    = ovf_q;

`ifdef SERIALIZER_CHKSUM_EN
   assign Dout = !DValid ? '0 : ((cnt_q == CW'(NWORDS)) ? chk_q : top_word);
`else
   assign Dout = DValid ? top_word : '0;
`endif

endmodule

// File: tb/tb_aes_result_serializer.sv
// Scoreboard bench for aes_result_serializer: the reference model slices each captured result into
// expected words; a negedge monitor pops and compares every accepted word and checks Done/Busy timing.
module tb_aes_result_serializer;

   localparam int WIDTH  = 128;
   localparam int OUT_W  = 8;
   localparam int NWORDS = WIDTH / OUT_W;
`ifdef SERIALIZER_CHKSUM_EN
   localparam int NBEATS = NWORDS + 1;
`else
   localparam int NBEATS = NWORDS;
`endif

   logic             Clk = 1'b0;
   logic             Rst;
   logic [WIDTH-1:0] Result;
   logic             Ry;
   logic             DReady;
   logic             ClrOvf;
   logic [OUT_W-1:0] Dout;
   logic             DValid;
   logic             Busy;
   logic             Done;
   logic             Ovf;

   aes_result_serializer #(.WIDTH(WIDTH), .OUT_W(OUT_W)) dut (
      .Clk(Clk), .Rst(Rst), .Result(Result), .Ry(Ry), .DReady(DReady), .ClrOvf(ClrOvf),
      .Dout(Dout), .DValid(DValid), .Busy(Busy), .Done(Done), .Ovf(Ovf)
   );

   always #5 Clk = ~Clk;

   int               checks = 0;
   int               errors = 0;
   int               cyc = 0;
   logic [OUT_W-1:0] exp_q[$];
   int               popped = 0;
   int               dones = 0;
   int               first_acc = 0;
   int               last_acc = 0;
   bit               done_due = 0;
   bit               idle_due = 0;
   bit               hold_chk = 0;
   logic [OUT_W-1:0] held;
   int               rdy_mode = 0;

   always @(posedge Clk) cyc++;

   task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: words are plain slices of the captured result, top word first.
   task automatic push_block(input logic [WIDTH-1:0] data);
      logic [OUT_W-1:0] chk;
      logic [OUT_W-1:0] w;
      chk = '0;
      for (int i = 0; i < NWORDS; i++) begin
         w = OUT_W'(data >> (WIDTH - OUT_W * (i + 1)));
         exp_q.push_back(w);
         chk ^= w;
      end
`ifdef SERIALIZER_CHKSUM_EN
      exp_q.push_back(chk);
`endif
   endtask

   // DReady driver: 0 = always ready, 1 = pattern 1,0,0,1 repeating, 2 = random.
   initial begin
      int idx;
      idx = 0;
      DReady = 1'b1;
      forever begin
         @(posedge Clk);
         #1;
         case (rdy_mode)
            1:       begin DReady = (idx % 4 == 0) || (idx % 4 == 3); idx++; end
            2:       DReady = 1'($urandom_range(0, 1));
            default: DReady = 1'b1;
         endcase
      end
   end

   // Monitor: compares accepted words, stall stability and end-of-block signalling.
   initial begin
      logic [OUT_W-1:0] e;
      forever begin
         @(negedge Clk);
         if (!Rst) begin
            if (idle_due) begin
               check("busy_after_done", {Busy, Done}, 2'b00);
               idle_due = 0;
            end
            if (done_due) begin
               check("done_pulse", {Done, DValid, Busy}, 3'b101);
               done_due = 0;
               idle_due = 1;
               dones++;
            end else if (Done) begin
               check("spurious_done", Done, 1'b0);
            end
            if (hold_chk) begin
               check("stall_hold", {DValid, Dout}, {1'b1, held});
               hold_chk = 0;
            end
            if (DValid && DReady) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_word: got %0h expected no word (t=%0t)", Dout, $time);
               end else begin
                  e = exp_q.pop_front();
                  check("word", Dout, e);
                  popped++;
                  if (popped == 1) first_acc = cyc;
                  last_acc = cyc;
                  if (exp_q.size() == 0) done_due = 1;
               end
            end else if (DValid) begin
               held     = Dout;
               hold_chk = 1;
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic clear_sb();
      exp_q.delete();
      done_due = 0;
      idle_due = 0;
      hold_chk = 0;
      popped   = 0;
   endtask

   task automatic start_block(input logic [WIDTH-1:0] data, input int ry_cycles, input bit scramble);
      Result = data;
      Ry     = 1'b1;
      push_block(data);
      tick();
      if (scramble) Result = {$urandom, $urandom, $urandom, $urandom};
      repeat (ry_cycles - 1) tick();
      Ry = 1'b0;
   endtask

   task automatic wait_popped(input int n, input int budget);
      int k;
      k = 0;
      while (popped < n && k < budget) begin tick(); k++; end
      check("wait_words_timeout", popped >= n, 1'b1);
   endtask

   task automatic wait_idle(input int budget);
      int k;
      k = 0;
      while ((exp_q.size() != 0 || done_due || idle_due) && k < budget) begin tick(); k++; end
      check("wait_idle_timeout", exp_q.size() == 0 && !done_due && !idle_due, 1'b1);
      tick();
   endtask

   initial begin
      int d0;
      logic [WIDTH-1:0] data;
      Rst = 1'b1; Ry = 1'b0; ClrOvf = 1'b0; Result = '0;
      repeat (3) tick();
      check("reset_outputs", {Dout, DValid, Busy, Done, Ovf}, '0);
      Rst = 1'b0;
      tick();

      // T2 basic stream with DReady always high
      check("t2_idle_before", DValid, 1'b0);
      d0 = dones;
      start_block(128'h03c18e199ba5296289328eca914a59aa, 1, 1'b0);
      check("t2_latency", DValid, 1'b1);
      wait_idle(100);
      check("t2_consecutive", last_acc - first_acc, NBEATS - 1);
      check("t2_one_done", dones - d0, 1);

      // T1 async reset mid-block: outputs clear without a clock edge
      clear_sb();
      start_block(128'h00112233445566778899aabbccddeeff, 1, 1'b0);
      wait_popped(3, 50);
      #2 Rst = 1'b1;
      #1 check("t1_async_reset", {Dout, DValid, Busy, Done, Ovf}, '0);
      clear_sb();
      tick();
      Rst = 1'b0;
      tick();

      // T3 backpressure
      rdy_mode = 1;
      d0 = dones;
      start_block(128'h5b448dd8c1beb2c7653f07f878c2c8e0, 1, 1'b1);
      wait_idle(200);
      check("t3_one_done", dones - d0, 1);
      rdy_mode = 0;
      tick();

      // T4 Ry held high: exactly one block
      clear_sb();
      d0 = dones;
      start_block(128'hfedcba9876543210f0e1d2c3b4a59687, 40, 1'b0);
      wait_idle(100);
      check("t4_one_block", dones - d0, 1);
      check("t4_no_ovf", Ovf, 1'b0);

      // T5 overrun mid-block, then clear; then clear and overrun together
      clear_sb();
      d0 = dones;
      start_block(128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0, 1, 1'b0);
      wait_popped(5, 50);
      Result = {$urandom, $urandom, $urandom, $urandom};
      Ry = 1'b1;
      tick();
      Ry = 1'b0;
      check("t5_ovf_set", Ovf, 1'b1);
      wait_idle(100);
      check("t5_one_block", dones - d0, 1);
      repeat (3) tick();
      check("t5_ovf_sticky", Ovf, 1'b1);
      ClrOvf = 1'b1;
      tick();
      ClrOvf = 1'b0;
      check("t5_ovf_cleared", Ovf, 1'b0);
      clear_sb();
      start_block(128'h13579bdf2468ace0deadbeefcafef00d, 1, 1'b0);
      wait_popped(3, 50);
      Ry = 1'b1; ClrOvf = 1'b1;
      tick();
      Ry = 1'b0; ClrOvf = 1'b0;
      check("t5_set_wins", Ovf, 1'b1);
      wait_idle(100);
      ClrOvf = 1'b1;
      tick();
      ClrOvf = 1'b0;
      check("t5_ovf_cleared2", Ovf, 1'b0);

      // T6 reset at byte 8, then restart from byte 0
      clear_sb();
      data = 128'ha1b2c3d4e5f60718293a4b5c6d7e8f90;
      start_block(data, 1, 1'b0);
      wait_popped(8, 50);
      #2 Rst = 1'b1;
      #1 check("t6_reset_idle", {DValid, Busy}, 2'b00);
      clear_sb();
      tick();
      Rst = 1'b0;
      tick();
      start_block(data, 1, 1'b0);
      wait_idle(100);
      check("t6_full_restart", popped, NBEATS);

      // Random blocks, random backpressure, Result scrambled after capture
      rdy_mode = 2;
      for (int b = 0; b < 6; b++) begin
         clear_sb();
         d0 = dones;
         start_block({$urandom, $urandom, $urandom, $urandom}, $urandom_range(1, 3), 1'b1);
         wait_idle(300);
         check("rand_block_done", dones - d0, 1);
         check("rand_block_beats", popped, NBEATS);
         repeat ($urandom_range(0, 3)) tick();
      end
      check("rand_no_ovf", Ovf, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
